// File: rtl/arvi_fetch_pkg.sv
// Shared definitions for the instruction prefetch unit: FSM encoding and entry sizing.
package arvi_fetch_pkg;

    // Fetch sequencer states. DRAIN waits for a stale request to finish after a redirect.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // One queue entry carries {pc, instruction}.
    function automatic int unsigned entry_w(input int unsigned xlen);
        return 32'd2 * xlen;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular {pc,inst} buffer with flush. Head data comes straight from registered storage.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_s;
    logic             push_s;

    // A pop on an empty queue is ignored; a flush suppresses any write.
    assign pop_s  = pop_i & (count_q != CNT_W'(1'b0));
    assign push_s = push_i & ~flush_i;

    // Next pointer/occupancy; push and pop together leave the count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = PTR_W'(1'b0);
            wr_ptr_d = PTR_W'(1'b0);
            count_d  = CNT_W'(1'b0);
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1'b1);
                2'b01:   count_d = count_q - CNT_W'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= PTR_W'(1'b0);
            wr_ptr_q <= PTR_W'(1'b0);
            count_q  <= CNT_W'(1'b0);
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero until the first write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch front end: sequential fetch into a small queue, redirect with
// flush, and safe draining of a request that is still in flight when a redirect arrives.
module if_prefetch_unit
    import arvi_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = {XLEN{1'b0}},
    parameter int unsigned     DEPTH    = 4,
    localparam int unsigned    CNT_W    = $clog2(DEPTH) + 1,
    localparam int unsigned    ENTRY_W  = entry_w(XLEN)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic             o_mem_req,
    output logic [XLEN-1:0]  o_mem_addr,
    input  logic             i_mem_ready,
    input  logic [XLEN-1:0]  i_mem_data,
    output logic             o_valid,
    output logic [XLEN-1:0]  o_inst,
    output logic [XLEN-1:0]  o_pc,
    input  logic             i_ready,
    input  logic             i_redirect,
    input  logic [XLEN-1:0]  i_redirect_pc,
    output logic [CNT_W-1:0] o_count
);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]  target_q, target_d;
    logic             req_q, req_d;

    logic [XLEN-1:0]  redirect_pc_s;
    logic             mem_done_s;
    logic             pop_s;
    logic             push_s;
    logic             fill_s;
    logic [CNT_W-1:0] count_s;
    logic [ENTRY_W-1:0] head_s;

    // Targets are always word aligned; misalignment is reported elsewhere.
    assign redirect_pc_s = i_redirect_pc & ~XLEN'(2'd3);
    // A ready pulse only counts while a request is actually outstanding.
    assign mem_done_s    = req_q & i_mem_ready;
    // A redirect wins over a same-cycle pop.
    assign pop_s         = (count_s != CNT_W'(1'b0)) & i_ready & ~i_redirect;
    assign push_s        = (state_q == ST_FETCH) & mem_done_s & ~i_redirect;
    // This push leaves the queue full, so fetching must pause.
    assign fill_s        = push_s & ~pop_s & (count_s == CNT_W'(DEPTH - 32'd1));

    // Next-state logic for the fetch sequencer, fetch PC and pending redirect target.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        target_d   = target_q;
        case (state_q)
            ST_FETCH: begin
                if (i_redirect) begin
                    if (mem_done_s || !req_q) begin
                        // Nothing left in flight: restart immediately.
                        fetch_pc_d = redirect_pc_s;
                        state_d    = ST_FETCH;
                    end else begin
                        target_d = redirect_pc_s;
                        state_d  = ST_DRAIN;
                    end
                end else if (mem_done_s) begin
                    fetch_pc_d = fetch_pc_q + XLEN'(3'd4);
                    if (fill_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_IDLE: begin
                if (i_redirect) begin
                    fetch_pc_d = redirect_pc_s;
                    state_d    = ST_FETCH;
                end else if (pop_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    if (mem_done_s) begin
                        fetch_pc_d = redirect_pc_s;
                        state_d    = ST_FETCH;
                    end else begin
                        target_d = redirect_pc_s;
                        state_d  = ST_DRAIN;
                    end
                end else if (mem_done_s) begin
                    fetch_pc_d = target_q;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        req_d = (state_d != ST_IDLE);
    end

    // Sequencer registers; the request line is registered so it stays low during reset.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= ST_FETCH;
            fetch_pc_q <= PC_RESET;
            target_q   <= PC_RESET;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            target_q   <= target_d;
            req_q      <= req_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_ni  (i_rst),
        .flush_i (i_redirect),
        .push_i  (push_s),
        .data_i  ({fetch_pc_q, i_mem_data}),
        .pop_i   (pop_s),
        .head_o  (head_s),
        .count_o (count_s)
    );

    assign o_mem_req  = req_q;
    assign o_mem_addr = fetch_pc_q;
    assign o_valid    = (count_s != CNT_W'(1'b0));
    assign o_pc       = head_s[ENTRY_W-1:XLEN];
    assign o_inst     = head_s[XLEN-1:0];
    assign o_count    = count_s;

endmodule
